// File: rtl/pattern_resp_pkg.sv
// Shared types and defaults for the pattern response compactor.
// Optional feature macro used by pattern_resp_misr: PATTERN_RESP_XMASK_EN.
package pattern_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } resp_state_e;

  localparam int unsigned DEF_RESP_W = 8;
  localparam int unsigned DEF_SIG_W  = 16;
  localparam int unsigned DEF_CNT_W  = 16;

  // x^16 + x^12 + x^5 + 1, Galois form
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'h0000;

endpackage

// File: rtl/pattern_misr_step.sv
// One MISR step: shift left, fold in feedback polynomial on MSB carry-out,
// xor the zero-extended response vector into the low bits.
module pattern_misr_step #(
  parameter int unsigned SIG_W  = 16,
  parameter int unsigned RESP_W = 8
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [RESP_W-1:0] resp,
  input  logic [SIG_W-1:0]  poly,
  output logic [SIG_W-1:0]  next_sig
);

  // Galois next-state function
  always_comb begin
    next_sig = {sig[SIG_W-2:0], 1'b0} ^ SIG_W'(resp);
    if (sig[SIG_W-1]) begin
      next_sig = next_sig ^ poly;
    end
  end

endmodule

// File: rtl/pattern_resp_misr.sv
// Response compactor: folds a programmed number of valid response vectors
// from a merged pattern circuit into a MISR and compares with a golden value.
// Optional: `define PATTERN_RESP_XMASK_EN adds resp_mask (1 = force bit to 0).
module pattern_resp_misr
  import pattern_resp_pkg::*;
#(
  parameter int unsigned      RESP_W = DEF_RESP_W,
  parameter int unsigned      SIG_W  = DEF_SIG_W,
  parameter int unsigned      CNT_W  = DEF_CNT_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED)
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_in,
`ifdef PATTERN_RESP_XMASK_EN
  input  logic [RESP_W-1:0] resp_mask,
`endif
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  samples_left
);

  resp_state_e       state;
  logic [RESP_W-1:0] resp_eff;
  logic [SIG_W-1:0]  next_sig;

  // Masked-off response bits contribute nothing to the signature
  always_comb begin
`ifdef PATTERN_RESP_XMASK_EN
    resp_eff = resp_in & ~resp_mask;
`else
    resp_eff = resp_in;
`endif
  end

  pattern_misr_step #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W)
  ) u_step (
    .sig      (signature),
    .resp     (resp_eff),
    .poly     (POLY),
    .next_sig (next_sig)
  );

  // Control FSM, sample counter, signature register and golden compare
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state        <= IDLE;
      signature    <= SEED;
      samples_left <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // The start cycle's resp_in is deliberately not absorbed
          if (start) begin
            signature <= SEED;
            if (num_cycles != '0) begin
              samples_left <= num_cycles;
              state        <= RUN;
              busy         <= 1'b1;
              done         <= 1'b0;
              pass         <= 1'b0;
            end else begin
              samples_left <= '0;
              state        <= DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              pass         <= (SEED == golden_sig);
            end
          end
        end
        RUN: begin
          if (resp_valid && (samples_left != '0)) begin
            signature    <= next_sig;
            samples_left <= samples_left - CNT_W'(1);
            // Compare against the value being written, so pass is
            // valid in the same cycle done rises
            if (samples_left == CNT_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (next_sig == golden_sig);
            end
          end
        end
        default: begin
          state        <= IDLE;
          samples_left <= '0;
          busy         <= 1'b0;
          done         <= 1'b0;
          pass         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_resp_misr.md
Name: pattern_resp_misr

Overview:
- Response compactor directly downstream of the merged pattern netlists.
- Consumes the registered output vector of a merged circuit, e.g. the 8 outputs N1371_0 .. N1508_10.
- Folds a programmed number of valid response vectors into a multiple-input signature register (MISR).
- Flags pass/fail against a golden signature, so merged-graph benchmarks self-check in simulation and on the bench.

Parameters:
- RESP_W, 8, width of response vector from the merged circuit
- SIG_W, 16, signature width; must be >= RESP_W
- CNT_W, 16, sample counter width
- POLY, 16'h1021, Galois feedback polynomial (x^16+x^12+x^5+1), low SIG_W bits used
- SEED, 16'h0000, signature value loaded on start

Ports:
- blif_clk_net  in  1  single clock, all state on rising edge
- blif_reset_net  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a compaction run
- num_cycles  in  CNT_W  number of valid samples to absorb; sampled on start
- resp_valid  in  1  resp_in holds a sample this cycle
- resp_in  in  RESP_W  response vector from the merged circuit
- golden_sig  in  SIG_W  expected signature; sampled on entry to DONE
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  signature == golden_sig; valid while done
- signature  out  SIG_W  current MISR contents
- samples_left  out  CNT_W  remaining samples in the run

Behaviour:
- Reset:
  - Asynchronous assert of blif_reset_net, active-high.
  - state=IDLE, signature=SEED, samples_left=0, busy=0, done=0, pass=0.
  - Reset asserted mid-RUN aborts immediately; no partial result is retained.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 and num_cycles!=0: signature<=SEED, samples_left<=num_cycles, go RUN.
  - start=1 and num_cycles==0: signature<=SEED, go DONE; pass computed against SEED.
- RUN:
  - On each cycle with resp_valid=1:
    - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero_extend(resp_in).
    - samples_left <= samples_left-1.
  - resp_valid=0: signature and samples_left hold.
  - When the sample with samples_left==1 is absorbed, go DONE next edge.
  - start is ignored in RUN.
- DONE:
  - done=1; pass <= (next signature == golden_sig) registered on the DONE-entry edge.
  - signature frozen; resp_valid ignored.
  - Stays in DONE until start; start in DONE behaves exactly as start in IDLE (restart, done drops next cycle).
- Latency: done rises one edge after the final valid sample, and pass is valid on that same cycle.
- Simultaneous start and resp_valid in IDLE/DONE: the start cycle's resp_in is NOT compacted; the first absorbed sample is in the cycle after start.
- Counter never wraps: decrement only when samples_left>0 and resp_valid.
- busy and done are mutually exclusive and both are registered outputs.

Optional Feature:
- Macro: PATTERN_RESP_XMASK_EN.
- Defined: adds input resp_mask [RESP_W]. Bits with resp_mask=1 are forced to 0 before compaction, which masks unknown/X-prone outputs such as un-reset flop outputs.
- Undefined: no resp_mask port; all resp_in bits are compacted.

Decomposition:
- Shared package pattern_resp_pkg:
  - state enum resp_state_e {IDLE, RUN, DONE}
  - default POLY and SEED constants
  - RESP_W/SIG_W defaults
- One sub-module, pattern_misr_step: purely combinational next-signature function (signature, resp, poly) -> next signature. It is reused by the testbench golden model.
- Top contains the FSM, counter and compare.

Test Plan:
- Reset mid-RUN: start, num_cycles=5, absorb 2 samples, assert blif_reset_net -> immediately busy=0, done=0, signature=16'h0000, samples_left=0.
- Single sample: start num_cycles=1, next cycle resp_valid=1 resp_in=8'h01, golden_sig=16'h0001 -> next edge done=1, pass=1, signature=16'h0001.
- Cancellation: num_cycles=2, samples 8'h01 then 8'h02 -> signature=16'h0000, done after 2nd sample.
- Feedback path: num_cycles=10, resp_in=8'h80 then nine 8'h00 -> signature=16'h1021; golden_sig=16'h1022 gives pass=0.
- Stall and zero-length:
  - num_cycles=3 with resp_valid toggled 1,0,0,1,0,1 -> samples_left 3,2,2,2,1,1,0; done 6 cycles after first valid.
  - start with num_cycles=0 and golden_sig=16'h0000 -> DONE next edge, pass=1.
- XMASK (macro defined): resp_mask=8'hFF, num_cycles=4, arbitrary resp_in -> signature=16'h0000, pass=1 against 16'h0000.
